alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  ROB-side issue stage feeding the dual ALU over ifc_rob_alu (rob modport). Buffers dispatched
//  ALU ops, tracks operand readiness via tag wakeup, issues up to two ready ops per cycle on
//  slots 1/2, captures result1/result2 and drives two registered writeback ports back to the ROB.
// PARAMETERS
//  OPRAND_WIDTH   32  operand/result width
//  OP_FUNC_WIDTH  17  op_func width ([6:0] = opcode)
//  DEPTH          8   queue entries (power of 2)
//  TAG_WIDTH      5   ROB tag width
// PORTS
//  clk         in   1       clock
//  rst         in   1       asynchronous reset, active-high
//  flush_i     in   1       synchronous kill of all queued/in-flight ops
//  disp_valid_i in  1       dispatch request
//  disp_ready_o out 1       >=1 free entry
//  disp_tag_i  in   TAG     destination ROB tag
//  disp_func_i in   OP_FUNC op_func
//  disp_opN_i  in   OPRAND  operand N (N=1,2)
//  disp_rdyN_i in   1       operand N value valid
//  disp_srcN_i in   TAG     producer tag of operand N when not ready
//  cdb_valid_i in   2       external wakeup broadcast valid, per lane
//  cdb_tag_i   in   2xTAG   broadcast tags
//  cdb_data_i  in   2xOPRAND broadcast data
//  alu_rob     ifc  -       ifc_rob_alu.rob: drives operand11/12/21/22, op_func1/2; reads result1/2
//  wbK_valid_o out  1       writeback K valid (K=1,2)
//  wbK_tag_o   out  TAG     writeback K tag
//  wbK_data_o  out  OPRAND  writeback K result
// BEHAVIOUR
//  Reset (async): all entry valids 0, issue regs invalid, op_func1/2 = 0 (NOP), operands 0,
//   wb*_valid_o 0, wb tags/data 0; disp_ready_o 1 after reset.
//  Dispatch: accepted when disp_valid_i & disp_ready_o; writes lowest-index free entry.
//   If a cdb lane matches disp_srcN_i in the same cycle, entry stores cdb data, marks ready.
//  Wakeup: each cycle every valid entry compares non-ready src tags to both cdb lanes; match
//   latches data and sets ready. Both lanes matching same tag: lane 0 wins.
//  Select: among entries with both operands ready, two lowest indices chosen; first -> slot 1,
//   second -> slot 2. Chosen entries freed same edge (re-allocatable next cycle).
//  Latency: select at edge N loads issue regs; ALU combinational in cycle N+1; result captured
//   into wb regs at edge N+1; wb*_valid_o high for exactly one cycle after edge N+1.
//  Empty slot: operands 0, op_func 0 (NOP); corresponding wb*_valid_o 0 next cycle.
//  Full: disp_ready_o = 0 when all DEPTH valid; a dispatch in same cycle as select is NOT
//   accepted into a just-freed entry (ready computed from registered state).
//  Only one ready entry: goes to slot 1, slot 2 idle. Slot order never swaps wb ports.
//  flush_i: next edge clears entry valids, issue regs, wb valids; dispatch same cycle dropped.
//  Reset mid-op: in-flight results discarded; no writeback produced.
// CONFIGURATION
//  ALU_BYPASS_EN defined: wb1/wb2 registered results also act as internal wakeup lanes (same
//   compare path as cdb), so dependants can issue the cycle after writeback without cdb.
//  Undefined: wakeup only via cdb_*_i; own writebacks must be returned by the ROB over cdb.
// STRUCTURE
//  Package alu_iq_pkg: iq_entry_t {valid, tag, func, op1, op2, rdy1, rdy2, src1, src2},
//   issue_slot_t {valid, tag, func, op1, op2}, OP_NOP constant (all zero).
//  Sub-module alu_iq_select: combinational two-lowest-ready picker (ready vector -> two
//   one-hot grants + valid flags). Queue storage, wakeup, issue/wb regs stay in top.
// TESTING
//  Dispatch ADD tag 3, ops 5/7 both ready -> op_func1=ADD, operand11=5 next cycle;
//   wb1_valid=1, tag 3, data 12 two cycles after dispatch; wb2_valid=0.
//  Dispatch tag 4 with src1=9 not ready, then cdb tag 9 data 100 -> issues cycle after
//   wakeup with operand11=100; no issue before.
//  Two ready entries at idx 0,1 -> slot1=idx0, slot2=idx1 same cycle; both wb valid together.
//  Fill 8 entries with unready ops -> disp_ready_o=0; one wakeup+issue frees entry,
//   disp_ready_o=1 next cycle.
//  flush_i with 3 queued + 2 in flight -> no wb*_valid_o afterwards, disp_ready_o=1.
//  ALU_BYPASS_EN: op B sourcing op A's tag issues cycle after A's wb, no cdb; without macro
//   B waits for cdb.

Source files
------------

// File: rtl/alu_iq_pkg.sv
// Shared types and sizing for the ALU issue queue and its ROB<->ALU interface.
package alu_iq_pkg;
    localparam int OPRAND_WIDTH  = 32;
    localparam int OP_FUNC_WIDTH = 17;
    localparam int DEPTH         = 8;
    localparam int TAG_WIDTH     = 5;
    localparam int IDX_W         = $clog2(DEPTH);

    localparam logic [OP_FUNC_WIDTH-1:0] OP_NOP = '0;

    typedef struct packed {
        logic                     valid;
        logic [TAG_WIDTH-1:0]     tag;
        logic [OP_FUNC_WIDTH-1:0] func;
        logic [OPRAND_WIDTH-1:0]  op1;
        logic [OPRAND_WIDTH-1:0]  op2;
        logic                     rdy1;
        logic                     rdy2;
        logic [TAG_WIDTH-1:0]     src1;
        logic [TAG_WIDTH-1:0]     src2;
    } iq_entry_t;

    typedef struct packed {
        logic                     valid;
        logic [TAG_WIDTH-1:0]     tag;
        logic [OP_FUNC_WIDTH-1:0] func;
        logic [OPRAND_WIDTH-1:0]  op1;
        logic [OPRAND_WIDTH-1:0]  op2;
    } issue_slot_t;
endpackage

// File: rtl/ifc_rob_alu.sv
// Operand/opcode bundle from the ROB issue stage to the dual ALU and its two results back.
interface ifc_rob_alu;
    import alu_iq_pkg::*;

    logic [OPRAND_WIDTH-1:0]  operand11;
    logic [OPRAND_WIDTH-1:0]  operand12;
    logic [OPRAND_WIDTH-1:0]  operand21;
    logic [OPRAND_WIDTH-1:0]  operand22;
    logic [OP_FUNC_WIDTH-1:0] op_func1;
    logic [OP_FUNC_WIDTH-1:0] op_func2;
    logic [OPRAND_WIDTH-1:0]  result1;
    logic [OPRAND_WIDTH-1:0]  result2;

    modport rob (
        output operand11, operand12, operand21, operand22, op_func1, op_func2,
        input  result1, result2
    );

    modport alu (
        input  operand11, operand12, operand21, operand22, op_func1, op_func2,
        output result1, result2
    );
endinterface

// File: rtl/alu_iq_select.sv
// Combinational picker: one-hot grants for the lowest and second-lowest set bits of ready_i.
module alu_iq_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] ready_i,
    output logic [N-1:0] gnt1_o,
    output logic [N-1:0] gnt2_o,
    output logic         gnt1_valid_o,
    output logic         gnt2_valid_o
);
    logic [N-1:0] rest;

    // x & -x isolates the lowest set bit
    assign gnt1_o       = ready_i & (~ready_i + N'(1));
    assign rest         = ready_i & ~gnt1_o;
    assign gnt2_o       = rest & (~rest + N'(1));
    assign gnt1_valid_o = |ready_i;
    assign gnt2_valid_o = |rest;
endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: tag-wakeup buffer, dual-slot issue to the ALU, registered writeback.
// Build option ALU_BYPASS_EN: own writebacks also act as wakeup lanes.
module alu_issue_queue
    import alu_iq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  logic [TAG_WIDTH-1:0]      disp_tag_i,
    input  logic [OP_FUNC_WIDTH-1:0]  disp_func_i,
    input  logic [OPRAND_WIDTH-1:0]   disp_op1_i,
    input  logic                      disp_rdy1_i,
    input  logic [TAG_WIDTH-1:0]      disp_src1_i,
    input  logic [OPRAND_WIDTH-1:0]   disp_op2_i,
    input  logic                      disp_rdy2_i,
    input  logic [TAG_WIDTH-1:0]      disp_src2_i,
    input  logic [1:0]                cdb_valid_i,
    input  logic [2*TAG_WIDTH-1:0]    cdb_tag_i,
    input  logic [2*OPRAND_WIDTH-1:0] cdb_data_i,
    ifc_rob_alu.rob                   alu_rob,
    output logic                      wb1_valid_o,
    output logic [TAG_WIDTH-1:0]      wb1_tag_o,
    output logic [OPRAND_WIDTH-1:0]   wb1_data_o,
    output logic                      wb2_valid_o,
    output logic [TAG_WIDTH-1:0]      wb2_tag_o,
    output logic [OPRAND_WIDTH-1:0]   wb2_data_o
);
`ifdef ALU_BYPASS_EN
    localparam int NLANES = 4;
`else
    localparam int NLANES = 2;
`endif

    iq_entry_t   entries_q [DEPTH];
    iq_entry_t   entries_d [DEPTH];
    issue_slot_t issue1_q, issue1_d, issue2_q, issue2_d;
    logic                    wb1_valid_q, wb2_valid_q;
    logic [TAG_WIDTH-1:0]    wb1_tag_q, wb2_tag_q;
    logic [OPRAND_WIDTH-1:0] wb1_data_q, wb2_data_q;

    logic [DEPTH-1:0] valid_vec, ready_vec, gnt1, gnt2;
    logic             gnt1_valid, gnt2_valid, disp_fire;
    logic [IDX_W-1:0] free_idx;

    logic [NLANES-1:0]                   lane_valid;
    logic [NLANES-1:0][TAG_WIDTH-1:0]    lane_tag;
    logic [NLANES-1:0][OPRAND_WIDTH-1:0] lane_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cdb_lane
            assign lane_valid[gi] = cdb_valid_i[gi];
            assign lane_tag[gi]   = cdb_tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
            assign lane_data[gi]  = cdb_data_i[gi*OPRAND_WIDTH +: OPRAND_WIDTH];
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign valid_vec[gi] = entries_q[gi].valid;
            assign ready_vec[gi] = entries_q[gi].valid & entries_q[gi].rdy1 & entries_q[gi].rdy2;
        end
    endgenerate

`ifdef ALU_BYPASS_EN
    assign lane_valid[3:2] = {wb2_valid_q, wb1_valid_q};
    assign lane_tag[3:2]   = {wb2_tag_q, wb1_tag_q};
    assign lane_data[3:2]  = {wb2_data_q, wb1_data_q};
`endif

    // Scan from the highest lane down so the lowest-numbered matching lane wins
    function automatic logic [OPRAND_WIDTH:0] wake(
        input logic                                rdy,
        input logic [TAG_WIDTH-1:0]                src,
        input logic [OPRAND_WIDTH-1:0]             op,
        input logic [NLANES-1:0]                   lv,
        input logic [NLANES-1:0][TAG_WIDTH-1:0]    lt,
        input logic [NLANES-1:0][OPRAND_WIDTH-1:0] ld
    );
        logic [OPRAND_WIDTH:0] r;
        r = {rdy, op};
        if (!rdy) begin
            for (int l = NLANES - 1; l >= 0; l--) begin
                if (lv[l] && lt[l] == src) r = {1'b1, ld[l]};
            end
        end
        return r;
    endfunction

    alu_iq_select #(.N(DEPTH)) u_select (
        .ready_i      (ready_vec),
        .gnt1_o       (gnt1),
        .gnt2_o       (gnt2),
        .gnt1_valid_o (gnt1_valid),
        .gnt2_valid_o (gnt2_valid)
    );

    // Ready is taken from registered state, so entries freed this edge are not reused until next cycle
    assign disp_ready_o = ~&valid_vec;
    assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;

    always_comb begin
        entries_d = entries_q;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            {entries_d[i].rdy1, entries_d[i].op1} = wake(entries_q[i].rdy1, entries_q[i].src1,
                                                         entries_q[i].op1, lane_valid, lane_tag, lane_data);
            {entries_d[i].rdy2, entries_d[i].op2} = wake(entries_q[i].rdy2, entries_q[i].src2,
                                                         entries_q[i].op2, lane_valid, lane_tag, lane_data);
            if (gnt1[i] | gnt2[i]) entries_d[i].valid = 1'b0;
        end
        if (disp_fire) begin
            entries_d[free_idx].valid = 1'b1;
            entries_d[free_idx].tag   = disp_tag_i;
            entries_d[free_idx].func  = disp_func_i;
            entries_d[free_idx].src1  = disp_src1_i;
            entries_d[free_idx].src2  = disp_src2_i;
            {entries_d[free_idx].rdy1, entries_d[free_idx].op1} =
                wake(disp_rdy1_i, disp_src1_i, disp_op1_i, lane_valid, lane_tag, lane_data);
            {entries_d[free_idx].rdy2, entries_d[free_idx].op2} =
                wake(disp_rdy2_i, disp_src2_i, disp_op2_i, lane_valid, lane_tag, lane_data);
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    // Unused slots carry all-zero fields, which presents a NOP to the ALU
    always_comb begin
        issue1_d = '0;
        issue2_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt1[i]) begin
                issue1_d.tag  = entries_q[i].tag;
                issue1_d.func = entries_q[i].func;
                issue1_d.op1  = entries_q[i].op1;
                issue1_d.op2  = entries_q[i].op2;
            end
            if (gnt2[i]) begin
                issue2_d.tag  = entries_q[i].tag;
                issue2_d.func = entries_q[i].func;
                issue2_d.op1  = entries_q[i].op1;
                issue2_d.op2  = entries_q[i].op2;
            end
        end
        issue1_d.valid = gnt1_valid;
        issue2_d.valid = gnt2_valid;
        if (flush_i) begin
            issue1_d = '0;
            issue2_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            issue1_q    <= '0;
            issue2_q    <= '0;
            wb1_valid_q <= 1'b0;
            wb1_tag_q   <= '0;
            wb1_data_q  <= '0;
            wb2_valid_q <= 1'b0;
            wb2_tag_q   <= '0;
            wb2_data_q  <= '0;
        end else begin
            entries_q   <= entries_d;
            issue1_q    <= issue1_d;
            issue2_q    <= issue2_d;
            wb1_valid_q <= issue1_q.valid & ~flush_i;
            wb2_valid_q <= issue2_q.valid & ~flush_i;
            if (issue1_q.valid) begin
                wb1_tag_q  <= issue1_q.tag;
                wb1_data_q <= alu_rob.result1;
            end
            if (issue2_q.valid) begin
                wb2_tag_q  <= issue2_q.tag;
                wb2_data_q <= alu_rob.result2;
            end
        end
    end

    assign alu_rob.op_func1  = issue1_q.func;
    assign alu_rob.operand11 = issue1_q.op1;
    assign alu_rob.operand12 = issue1_q.op2;
    assign alu_rob.op_func2  = issue2_q.func;
    assign alu_rob.operand21 = issue2_q.op1;
    assign alu_rob.operand22 = issue2_q.op2;

    assign wb1_valid_o = wb1_valid_q;
    assign wb1_tag_o   = wb1_tag_q;
    assign wb1_data_o  = wb1_data_q;
    assign wb2_valid_o = wb2_valid_q;
    assign wb2_tag_o   = wb2_tag_q;
    assign wb2_data_o  = wb2_data_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small behavioural dual ALU (ADD/SUB).
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

`ifdef ALU_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [16:0] F_ADD = 17'h00001;
    localparam logic [16:0] F_SUB = 17'h00002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [4:0]  disp_tag = '0, disp_src1 = '0, disp_src2 = '0;
    logic [16:0] disp_func = '0;
    logic [31:0] disp_op1 = '0, disp_op2 = '0;
    logic        disp_rdy1 = 1'b0, disp_rdy2 = 1'b0;
    logic [1:0]  cdb_valid = '0;
    logic [9:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        wb1_valid, wb2_valid;
    logic [4:0]  wb1_tag, wb2_tag;
    logic [31:0] wb1_data, wb2_data;

    int tests = 0;
    int fails = 0;

    ifc_rob_alu alu_if ();

    function automatic logic [31:0] alu(input logic [16:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f[6:0])
            7'h01:   return a + b;
            7'h02:   return a - b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_if.result1 = alu(alu_if.op_func1, alu_if.operand11, alu_if.operand12);
    assign alu_if.result2 = alu(alu_if.op_func2, alu_if.operand21, alu_if.operand22);

    alu_issue_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .disp_valid_i (disp_valid),
        .disp_ready_o (disp_ready),
        .disp_tag_i   (disp_tag),
        .disp_func_i  (disp_func),
        .disp_op1_i   (disp_op1),
        .disp_rdy1_i  (disp_rdy1),
        .disp_src1_i  (disp_src1),
        .disp_op2_i   (disp_op2),
        .disp_rdy2_i  (disp_rdy2),
        .disp_src2_i  (disp_src2),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .cdb_data_i   (cdb_data),
        .alu_rob      (alu_if),
        .wb1_valid_o  (wb1_valid),
        .wb1_tag_o    (wb1_tag),
        .wb1_data_o   (wb1_data),
        .wb2_valid_o  (wb2_valid),
        .wb2_tag_o    (wb2_tag),
        .wb2_data_o   (wb2_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_disp(input logic [4:0] tag, input logic [16:0] func,
                              input logic [31:0] o1, input logic r1, input logic [4:0] s1,
                              input logic [31:0] o2, input logic r2, input logic [4:0] s2);
        disp_valid = 1'b1;
        disp_tag   = tag;
        disp_func  = func;
        disp_op1   = o1;
        disp_rdy1  = r1;
        disp_src1  = s1;
        disp_op2   = o2;
        disp_rdy2  = r2;
        disp_src2  = s2;
    endtask

    initial begin
        logic        got;
        logic [31:0] got_data;

        // reset
        tick();
        tick();
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_wb1_valid", 64'(wb1_valid), 64'd0);
        chk("rst_wb2_valid", 64'(wb2_valid), 64'd0);
        chk("rst_wb1_tag", 64'(wb1_tag), 64'd0);
        chk("rst_wb1_data", 64'(wb1_data), 64'd0);
        chk("rst_op_func1", 64'(alu_if.op_func1), 64'd0);
        chk("rst_operand11", 64'(alu_if.operand11), 64'd0);
        rst = 1'b0;

        // single ready ADD
        drive_disp(5'd3, F_ADD, 32'd5, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        chk("t1_no_issue_yet", 64'(alu_if.op_func1), 64'd0);
        tick();
        chk("t1_func1", 64'(alu_if.op_func1), 64'(F_ADD));
        chk("t1_operand11", 64'(alu_if.operand11), 64'd5);
        chk("t1_operand12", 64'(alu_if.operand12), 64'd7);
        chk("t1_func2_nop", 64'(alu_if.op_func2), 64'd0);
        chk("t1_wb1_not_yet", 64'(wb1_valid), 64'd0);
        tick();
        chk("t1_wb1_valid", 64'(wb1_valid), 64'd1);
        chk("t1_wb1_tag", 64'(wb1_tag), 64'd3);
        chk("t1_wb1_data", 64'(wb1_data), 64'd12);
        chk("t1_wb2_valid", 64'(wb2_valid), 64'd0);
        tick();
        chk("t1_wb1_one_cycle", 64'(wb1_valid), 64'd0);

        // wakeup via cdb, both lanes same tag: lane 0 wins
        drive_disp(5'd4, F_ADD, 32'd0, 1'b0, 5'd9, 32'd1, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        tick();
        chk("t2_wait_a", 64'(alu_if.op_func1), 64'd0);
        tick();
        chk("t2_wait_b", 64'(alu_if.op_func1), 64'd0);
        cdb_valid = 2'b11;
        cdb_tag   = {5'd9, 5'd9};
        cdb_data  = {32'd200, 32'd100};
        tick();
        cdb_valid = 2'b00;
        chk("t2_wait_c", 64'(alu_if.op_func1), 64'd0);
        tick();
        chk("t2_func1", 64'(alu_if.op_func1), 64'(F_ADD));
        chk("t2_operand11", 64'(alu_if.operand11), 64'd100);
        tick();
        chk("t2_wb1_valid", 64'(wb1_valid), 64'd1);
        chk("t2_wb1_tag", 64'(wb1_tag), 64'd4);
        chk("t2_wb1_data", 64'(wb1_data), 64'd101);

        // cdb match during dispatch cycle
        drive_disp(5'd12, F_ADD, 32'd0, 1'b0, 5'd21, 32'd5, 1'b1, 5'd0);
        cdb_valid = 2'b10;
        cdb_tag   = {5'd21, 5'd0};
        cdb_data  = {32'd50, 32'd0};
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        tick();
        chk("t2b_func1", 64'(alu_if.op_func1), 64'(F_ADD));
        chk("t2b_operand11", 64'(alu_if.operand11), 64'd50);
        tick();
        chk("t2b_wb1_tag", 64'(wb1_tag), 64'd12);
        chk("t2b_wb1_data", 64'(wb1_data), 64'd55);

        // two entries ready in the same cycle
        drive_disp(5'd10, F_ADD, 32'd0, 1'b0, 5'd20, 32'd2, 1'b1, 5'd0);
        tick();
        drive_disp(5'd11, F_SUB, 32'd0, 1'b0, 5'd20, 32'd4, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 2'b01;
        cdb_tag    = {5'd0, 5'd20};
        cdb_data   = {32'd0, 32'd30};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("t3_func1", 64'(alu_if.op_func1), 64'(F_ADD));
        chk("t3_operand11", 64'(alu_if.operand11), 64'd30);
        chk("t3_func2", 64'(alu_if.op_func2), 64'(F_SUB));
        chk("t3_operand22", 64'(alu_if.operand22), 64'd4);
        tick();
        chk("t3_wb1_valid", 64'(wb1_valid), 64'd1);
        chk("t3_wb1_tag", 64'(wb1_tag), 64'd10);
        chk("t3_wb1_data", 64'(wb1_data), 64'd32);
        chk("t3_wb2_valid", 64'(wb2_valid), 64'd1);
        chk("t3_wb2_tag", 64'(wb2_tag), 64'd11);
        chk("t3_wb2_data", 64'(wb2_data), 64'd26);

        // fill the queue
        for (int i = 0; i < 7; i++) begin
            drive_disp(5'(16 + i), F_ADD, 32'd0, 1'b0, 5'(24 + i), 32'(i), 1'b1, 5'd0);
            tick();
        end
        chk("t4_ready_at7", 64'(disp_ready), 64'd1);
        drive_disp(5'd23, F_ADD, 32'd0, 1'b0, 5'd31, 32'd7, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        chk("t4_full", 64'(disp_ready), 64'd0);
        cdb_valid = 2'b01;
        cdb_tag   = {5'd0, 5'd24};
        cdb_data  = {32'd0, 32'h40};
        tick();
        cdb_valid = 2'b00;
        chk("t4_still_full", 64'(disp_ready), 64'd0);
        drive_disp(5'd30, F_ADD, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        chk("t4_ready_after_free", 64'(disp_ready), 64'd1);
        chk("t4_func1", 64'(alu_if.op_func1), 64'(F_ADD));
        chk("t4_operand11", 64'(alu_if.operand11), 64'h40);
        tick();
        chk("t4_wb1_valid", 64'(wb1_valid), 64'd1);
        chk("t4_wb1_tag", 64'(wb1_tag), 64'd16);
        chk("t4_wb1_data", 64'(wb1_data), 64'h40);
        chk("t4_wb2_valid", 64'(wb2_valid), 64'd0);
        tick();
        chk("t4_blocked_disp_absent", 64'(wb1_valid), 64'd0);

        // flush with queued and in-flight ops
        cdb_valid = 2'b11;
        cdb_tag   = {5'd26, 5'd25};
        cdb_data  = {32'd2, 32'd1};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("t5_inflight1", 64'(alu_if.operand11), 64'd1);
        chk("t5_inflight2", 64'(alu_if.operand21), 64'd2);
        flush = 1'b1;
        drive_disp(5'd29, F_ADD, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("t5_wb1_killed", 64'(wb1_valid), 64'd0);
        chk("t5_wb2_killed", 64'(wb2_valid), 64'd0);
        chk("t5_func1_nop", 64'(alu_if.op_func1), 64'd0);
        chk("t5_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        chk("t5_wb1_quiet", 64'(wb1_valid), 64'd0);
        chk("t5_drop_disp", 64'(alu_if.op_func1), 64'd0);
        cdb_valid = 2'b01;
        cdb_tag   = {5'd0, 5'd27};
        cdb_data  = {32'd0, 32'd9};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("t5_no_stale_issue", 64'(alu_if.op_func1), 64'd0);

        // dependant on own writeback
        drive_disp(5'd1, F_ADD, 32'd3, 1'b1, 5'd0, 32'd4, 1'b1, 5'd0);
        tick();
        drive_disp(5'd2, F_ADD, 32'd0, 1'b0, 5'd1, 32'd10, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        chk("t6_a_operand11", 64'(alu_if.operand11), 64'd3);
        tick();
        chk("t6_a_wb_tag", 64'(wb1_tag), 64'd1);
        chk("t6_a_wb_data", 64'(wb1_data), 64'd7);
        tick();
        chk("t6_b_not_yet", 64'(alu_if.op_func1), 64'd0);
        tick();
        chk("t6_b_bypass_issue", 64'(alu_if.op_func1), BYPASS ? 64'(F_ADD) : 64'd0);
        cdb_valid = 2'b01;
        cdb_tag   = {5'd0, 5'd1};
        cdb_data  = {32'd0, 32'd7};
        tick();
        cdb_valid = 2'b00;
        got      = 1'b0;
        got_data = '0;
        for (int k = 0; k < 6 && !got; k++) begin
            if (wb1_valid && wb1_tag == 5'd2) begin
                got      = 1'b1;
                got_data = wb1_data;
            end else begin
                tick();
            end
        end
        chk("t6_b_wb_seen", 64'(got), 64'd1);
        chk("t6_b_wb_data", 64'(got_data), 64'd17);
        tick();

        // reset while an op is in flight
        drive_disp(5'd7, F_ADD, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        tick();
        chk("t7_inflight", 64'(alu_if.op_func1), 64'(F_ADD));
        #2 rst = 1'b1;
        #1;
        chk("t7_async_func1", 64'(alu_if.op_func1), 64'd0);
        chk("t7_async_wb1", 64'(wb1_valid), 64'd0);
        chk("t7_async_ready", 64'(disp_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_no_wb_a", 64'(wb1_valid), 64'd0);
        tick();
        chk("t7_no_wb_b", 64'(wb1_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
